serial_addsub_3bit: RTL and testbench
=====================================

# serial_addsub_3bit

Multi-cycle, digit-serial adder/subtractor that computes A+B or A−B on WIDTH-bit operands, one 3-bit carry-lookahead digit per clock, LSB digit first, with the carry/borrow held in a register between digits. It is the subtract-capable, sequential companion to the team's 3-bit CLA slice, with one 3-bit slice of logic serving all digits. It sits between an operand source and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 12, operand and result width; must be a multiple of 3. NDIG = WIDTH/3.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand source has a request
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  minuend or augend; sampled only on accept
- b  in  WIDTH  subtrahend or addend; sampled only on accept
- sub  in  1  1 = A−B, 0 = A+B; sampled only on accept
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  sum or difference, modulo 2^WIDTH
- c_out  out  1  carry out of the MSB. For subtract, 1 = no borrow.
- borrow  out  1  sub & ~c_out, latched with the result
- ovf  out  1  two's-complement overflow
- zero  out  1  result == 0

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: digits in progress.
  - DONE: out_valid=1.
- Accept is in_valid & in_ready on a clock edge. On accept:
  - a_reg←a, b_reg←(sub ? ~b : b), carry←sub, sub_reg←sub.
  - cnt←0, state←RUN.
- Each RUN edge:
  - Compute the digit from a_reg[2:0], b_reg[2:0] and carry using 3-bit CLA generate/propagate equations (g=a&b, p=a^b, s=p^c, lookahead carries c0..c2).
  - Shift a_reg and b_reg right by 3.
  - Shift the digit sum into result from the top; result ← {s, result[WIDTH-1:3]}.
  - carry←c2, cnt←cnt+1.
- On the RUN edge with cnt==NDIG−1:
  - Also latch c_out←c2, ovf←c1^c2 of that digit, borrow←sub_reg & ~c2, zero←(final result==0).
  - state←DONE.
- DONE: out_valid=1. On an edge with out_ready=1, state←IDLE. result and flags hold until the next accept.
- in_valid in RUN or DONE is ignored. There is no queuing, and a, b and sub changes have no effect.
- Reset (asynchronous, any state, including mid-RUN): state←IDLE, in-flight operation discarded. Registers cleared: result, c_out, borrow, ovf, zero, cnt, carry ← 0. Outputs: out_valid=0, in_ready=1.
- result during RUN is a partial shift value and is meaningful only while out_valid=1.

## Timing
- Accept on edge T0. Digits are processed on edges T1..TNDIG. out_valid rises after edge TNDIG, giving a latency of NDIG cycles (4 for WIDTH=12).
- If out_ready is high in the first DONE cycle, state is IDLE after TNDIG+1. The earliest next accept is TNDIG+2, so back-to-back throughput is one operation per NDIG+2 cycles.
- out_ready low in DONE holds out_valid, result and flags stable indefinitely, with in_ready=0.
- out_ready is ignored outside DONE.
- in_ready and out_valid are decoded directly from the state register; there is no combinational path from in_valid or out_ready.

## Test plan
- WIDTH=12, add 0x123+0x456, sub=0 -> result 0x579, c_out 0, borrow 0, ovf 0, zero 0. out_valid rises exactly 4 cycles after the accept edge.
- Subtract 0x005−0x007 -> result 0xFFE, c_out 0, borrow 1, ovf 0, zero 0.
- Subtract 0x7FF−0xFFF (2047−(−1)) -> result 0x800, ovf 1, borrow 1, c_out 0.
- Add 0xFFF+0x001 -> result 0x000, c_out 1, zero 1, ovf 0.
- Backpressure case:
  - Stimulus: hold out_ready=0 for 6 cycles in DONE while toggling in_valid, a and b.
  - Response: out_valid stays 1, result and flags are unchanged, in_ready stays 0, and no new accept occurs.
  - On release, out_ready=1 for one cycle -> IDLE, and a new accept is possible 2 cycles after the last digit edge plus the release.
- Assert rst_n low asynchronously at cnt=2 of an operation -> out_valid=0, in_ready=1 and all outputs 0 immediately. After release, 0x0AB−0x0AB gives result 0x000, zero 1, c_out 1, borrow 0.

Source files
------------

// File: rtl/serial_addsub_3bit.sv
// Digit-serial adder/subtractor: one 3-bit carry-lookahead digit per clock, LSB first,
// with the carry held in a register between digits and valid/ready on both sides.

module cla3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] s,
  output logic [2:0] c
);
  logic [2:0] g, p;
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    s    = p ^ {c[1], c[0], cin};
  end
endmodule

module serial_addsub_3bit #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);
  localparam int NDIG = WIDTH / 3;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] a_reg, b_reg, res_nx;
  logic             carry, sub_reg;
  logic [CW-1:0]    cnt;
  logic [2:0]       s, c;
  logic             accept, last;

  cla3 u_cla (.a(a_reg[2:0]), .b(b_reg[2:0]), .cin(carry), .s(s), .c(c));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == LAST);
  // Digit sums enter from the top so the LSB digit ends up at bit 0 after NDIG shifts.
  assign res_nx    = {s, result[WIDTH-1:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last)     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      carry   <= 1'b0;
      sub_reg <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      c_out   <= 1'b0;
      borrow  <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (accept) begin
      // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
      a_reg   <= a;
      b_reg   <= sub ? ~b : b;
      carry   <= sub;
      sub_reg <= sub;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_reg  <= a_reg >> 3;
      b_reg  <= b_reg >> 3;
      result <= res_nx;
      carry  <= c[2];
      cnt    <= cnt + 1'b1;
      if (last) begin
        c_out  <= c[2];
        ovf    <= c[1] ^ c[2];
        borrow <= sub_reg & ~c[2];
        zero   <= (res_nx == '0);
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub_3bit.sv
// Randomized and directed bench for serial_addsub_3bit against an arithmetic reference model.

module tb_serial_addsub_3bit;
  localparam int WIDTH = 12;
  localparam int NDIG  = WIDTH / 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, sub, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, result;
  logic             c_out, borrow, ovf, zero;

  int checks = 0;
  int errors = 0;

  serial_addsub_3bit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out), .borrow(borrow), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic on the operands, independent of digit slicing.
  task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                       output logic [WIDTH-1:0] r, output logic co, output logic bo,
                       output logic ov, output logic z);
    int ux, uy, sx, sy, exact;
    ux = int'(x);
    uy = int'(y);
    sx = x[WIDTH-1] ? ux - (1 << WIDTH) : ux;
    sy = y[WIDTH-1] ? uy - (1 << WIDTH) : uy;
    if (s) begin
      r     = WIDTH'(ux - uy);
      co    = (ux >= uy);
      exact = sx - sy;
    end else begin
      r     = WIDTH'(ux + uy);
      co    = (ux + uy) >= (1 << WIDTH);
      exact = sx + sy;
    end
    bo = s & ~co;
    ov = (exact > (1 << (WIDTH-1)) - 1) || (exact < -(1 << (WIDTH-1)));
    z  = (r == '0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, input int hold);
    logic [WIDTH-1:0] r;
    logic co, bo, ov, z;
    int n;
    model(x, y, s, r, co, bo, ov, z);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    @(negedge clk);
    a = x; b = y; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
    chk("accept_ready", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'(NDIG));
    chk("result", 32'(result), 32'(r));
    chk("c_out",  32'(c_out),  32'(co));
    chk("borrow", 32'(borrow), 32'(bo));
    chk("ovf",    32'(ovf),    32'(ov));
    chk("zero",   32'(zero),   32'(z));
    repeat (hold) begin
      @(negedge clk);
      in_valid = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_flags", {16'(result), 12'd0, c_out, borrow, ovf, zero},
                        {16'(r), 12'd0, co, bo, ov, z});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 32'(in_ready), 32'd1);
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("idle_result", 32'(result), 32'(r));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", {16'(result), 12'd0, c_out, borrow, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(12'h123, 12'h456, 1'b0, 0);
    run_op(12'h005, 12'h007, 1'b1, 0);
    run_op(12'h7FF, 12'hFFF, 1'b1, 0);
    run_op(12'hFFF, 12'h001, 1'b0, 0);
    run_op(12'h800, 12'h001, 1'b1, 6);   // backpressure with input churn

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    a = 12'h321; b = 12'h123; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_outs", {16'(result), 12'd0, c_out, borrow, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(12'h0AB, 12'h0AB, 1'b1, 0);

    for (int i = 0; i < 40; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
